// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/freeze sequencing, operand forwarding and
// MEM-wait timeout supervision for a 5-stage RISC-V pipeline.
`default_nettype none

module pipeline_hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_load_Instr,
  input  logic             EX_RF_enable,
  input  logic             EX_branch_taken,
  input  logic [4:0]       MEM_rd,
  input  logic             MEM_RF_enable,
  input  logic             MEM_RAM_Enable,
  input  logic             mem_ready,
  input  logic [4:0]       WB_rd,
  input  logic             WB_RF_enable,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_flush,
  output logic             PC_src_sel,
  output logic             S,
  output logic             pipe_freeze,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             halt_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       halt_nxt;
  logic       memwait, loaduse;
  logic       stall_ev, flush_ev;

  assign memwait = MEM_RAM_Enable & ~mem_ready;
  assign loaduse = EX_load_Instr & EX_RF_enable & (EX_rd != 5'd0) &
                   ((ID_uses_rs1 & (ID_rs1 == EX_rd)) | (ID_uses_rs2 & (ID_rs2 == EX_rd)));

  always_comb begin
    PC_LE        = 1'b1;
    IF_ID_LE     = 1'b1;
    IF_ID_flush  = 1'b0;
    PC_src_sel   = 1'b0;
    S            = 1'b0;
    pipe_freeze  = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    halt_nxt     = halt_err;
    if (Reset) begin
      state_nxt = RUN;
    end else if (state == HALT) begin
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      pipe_freeze = 1'b1;
      S           = 1'b1;
    end else if (memwait) begin
      // EX is frozen too, so a pending branch stays asserted and is taken after release
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      pipe_freeze = 1'b1;
      stall_ev    = 1'b1;
      if (state == RUN) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = 8'd1;
      end else if (wait_cnt == WAIT_LAST) begin
        state_nxt = HALT;
        halt_nxt  = 1'b1;
      end else begin
        wait_cnt_nxt = wait_cnt + 8'd1;
      end
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = 8'd0;
      if (EX_branch_taken) begin
        PC_src_sel  = 1'b1;
        IF_ID_flush = 1'b1;
        S           = 1'b1;
        flush_ev    = 1'b1;
      end else if (loaduse) begin
        PC_LE    = 1'b0;
        IF_ID_LE = 1'b0;
        S        = 1'b1;
        stall_ev = 1'b1;
      end
    end
  end

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (!Reset) begin
      if (MEM_RF_enable && MEM_rd != 5'd0 && MEM_rd == ID_rs1)   fwdA = 2'b01;
      else if (WB_RF_enable && WB_rd != 5'd0 && WB_rd == ID_rs1) fwdA = 2'b10;
      if (MEM_RF_enable && MEM_rd != 5'd0 && MEM_rd == ID_rs2)   fwdB = 2'b01;
      else if (WB_RF_enable && WB_rd != 5'd0 && WB_rd == ID_rs2) fwdB = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      halt_err  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      halt_err <= halt_nxt;
      if (stall_ev && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// Directed, table-driven bench for pipeline_hazard_controller.
`default_nettype none

module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0, MEM_rd = '0, WB_rd = '0;
  logic       ID_uses_rs1 = 0, ID_uses_rs2 = 0, EX_load_Instr = 0, EX_RF_enable = 0;
  logic       EX_branch_taken = 0, MEM_RF_enable = 0, MEM_RAM_Enable = 0, mem_ready = 0, WB_RF_enable = 0;

  logic        PC_LE, IF_ID_LE, IF_ID_flush, PC_src_sel, S, pipe_freeze, halt_err;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stall_cnt, flush_cnt;

  logic        PC_LE4, IF_ID_LE4, IF_ID_flush4, PC_src_sel4, S4, pipe_freeze4, halt_err4;
  logic [1:0]  fwdA4, fwdB4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .Reset(Reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_rd(EX_rd),
    .EX_load_Instr(EX_load_Instr), .EX_RF_enable(EX_RF_enable), .EX_branch_taken(EX_branch_taken),
    .MEM_rd(MEM_rd), .MEM_RF_enable(MEM_RF_enable), .MEM_RAM_Enable(MEM_RAM_Enable),
    .mem_ready(mem_ready), .WB_rd(WB_rd), .WB_RF_enable(WB_RF_enable),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_flush(IF_ID_flush), .PC_src_sel(PC_src_sel),
    .S(S), .pipe_freeze(pipe_freeze), .fwdA(fwdA), .fwdB(fwdB), .halt_err(halt_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_controller #(.TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .Reset(Reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_rd(EX_rd),
    .EX_load_Instr(EX_load_Instr), .EX_RF_enable(EX_RF_enable), .EX_branch_taken(EX_branch_taken),
    .MEM_rd(MEM_rd), .MEM_RF_enable(MEM_RF_enable), .MEM_RAM_Enable(MEM_RAM_Enable),
    .mem_ready(mem_ready), .WB_rd(WB_rd), .WB_RF_enable(WB_RF_enable),
    .PC_LE(PC_LE4), .IF_ID_LE(IF_ID_LE4), .IF_ID_flush(IF_ID_flush4), .PC_src_sel(PC_src_sel4),
    .S(S4), .pipe_freeze(pipe_freeze4), .fwdA(fwdA4), .fwdB(fwdB4), .halt_err(halt_err4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic       u1, u2, ld, ex_rf, br, mem_rf, ram_en, rdy, wb_rf;
    logic [7:0] exp_ctl; // {PC_LE, IF_ID_LE, IF_ID_flush, PC_src_sel, S, pipe_freeze, 2'b0}
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {PC_LE, IF_ID_LE, IF_ID_flush, PC_src_sel, S, pipe_freeze, 2'b00};
  endfunction

  task automatic idle_inputs();
    ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0; MEM_rd = 0; WB_rd = 0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_load_Instr = 0; EX_RF_enable = 0;
    EX_branch_taken = 0; MEM_RF_enable = 0; MEM_RAM_Enable = 0; mem_ready = 0; WB_RF_enable = 0;
  endtask

  task automatic set_loaduse();
    EX_load_Instr = 1; EX_RF_enable = 1; EX_rd = 5; ID_rs2 = 5; ID_uses_rs2 = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    Reset = 1;
    @(negedge clk);
    Reset = 0;
  endtask

  localparam logic [7:0] FREE  = 8'b1100_0000;
  localparam logic [7:0] STALL = 8'b0000_1000;
  localparam logic [7:0] FLUSH = 8'b1111_1000;
  localparam logic [7:0] FRZ   = 8'b0000_0100;
  localparam logic [7:0] HALTC = 8'b0000_1100;

  initial begin
    //            rs1 rs2 exrd memrd wbrd u1 u2 ld exrf br memrf ram rdy wbrf ctl    fa     fb
    vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, FREE,  2'b00, 2'b00};
    vecs[1]  = '{0, 5, 5, 0, 0,  0, 1, 1, 1, 0, 0, 0, 0, 0, STALL, 2'b00, 2'b00};
    vecs[2]  = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0, 0, 0, 0, FREE,  2'b00, 2'b00};
    vecs[3]  = '{0, 5, 5, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, FREE,  2'b00, 2'b00};
    vecs[4]  = '{9, 0, 9, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 0, STALL, 2'b00, 2'b00};
    vecs[5]  = '{9, 0, 9, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, FREE,  2'b00, 2'b00};
    vecs[6]  = '{0, 5, 5, 0, 0,  0, 1, 1, 1, 1, 0, 0, 0, 0, FLUSH, 2'b00, 2'b00};
    vecs[7]  = '{7, 3, 0, 7, 7,  0, 0, 0, 0, 0, 1, 0, 0, 1, FREE,  2'b01, 2'b00};
    vecs[8]  = '{7, 3, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0, 0, 1, FREE,  2'b10, 2'b00};
    vecs[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1, FREE,  2'b00, 2'b00};
    vecs[10] = '{4, 4, 0, 4, 4,  0, 0, 0, 0, 0, 1, 0, 0, 1, FREE,  2'b01, 2'b01};
    vecs[11] = '{6, 2, 0, 9, 2,  0, 0, 0, 0, 0, 1, 1, 1, 1, FREE,  2'b00, 2'b10};
    vecs[12] = '{0, 5, 5, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0, 0, FREE,  2'b00, 2'b00};

    // Reset values, and idle outputs while Reset is held even with a hazard present
    @(negedge clk);
    set_loaduse();
    #1;
    chk("reset_ctl", ctl(), FREE);
    chk("reset_halt", halt_err, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    do_reset();

    foreach (vecs[i]) begin
      ID_rs1 = vecs[i].rs1; ID_rs2 = vecs[i].rs2; EX_rd = vecs[i].ex_rd;
      MEM_rd = vecs[i].mem_rd; WB_rd = vecs[i].wb_rd;
      ID_uses_rs1 = vecs[i].u1; ID_uses_rs2 = vecs[i].u2; EX_load_Instr = vecs[i].ld;
      EX_RF_enable = vecs[i].ex_rf; EX_branch_taken = vecs[i].br; MEM_RF_enable = vecs[i].mem_rf;
      MEM_RAM_Enable = vecs[i].ram_en; mem_ready = vecs[i].rdy; WB_RF_enable = vecs[i].wb_rf;
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
      chk($sformatf("vec%0d_fwdA", i), fwdA, vecs[i].exp_fa);
      chk($sformatf("vec%0d_fwdB", i), fwdB, vecs[i].exp_fb);
      @(negedge clk);
    end
    chk("table_stall_cnt", stall_cnt, 2);
    chk("table_flush_cnt", flush_cnt, 1);

    // Load-use: one bubble, then the load advances
    do_reset();
    set_loaduse();
    #1 chk("lu_ctl", ctl(), STALL);
    @(negedge clk);
    EX_load_Instr = 0; EX_RF_enable = 0; EX_rd = 0;
    #1 chk("lu_after_ctl", ctl(), FREE);
    chk("lu_stall_cnt", stall_cnt, 1);

    // Branch beats a simultaneous load-use
    @(negedge clk);
    set_loaduse(); EX_branch_taken = 1;
    #1 chk("br_lu_ctl", ctl(), FLUSH);
    @(negedge clk);
    idle_inputs();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);

    // Three MEM-wait cycles with a pending branch
    do_reset();
    MEM_RAM_Enable = 1; mem_ready = 0; EX_branch_taken = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("mw_frz%0d", c), ctl(), FRZ);
      @(negedge clk);
    end
    mem_ready = 1;
    #1 chk("mw_release_ctl", ctl(), FLUSH);
    @(negedge clk);
    chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_flush_cnt", flush_cnt, 1);
    EX_branch_taken = 0; mem_ready = 0;
    #1 chk("mw_rearm_ctl", ctl(), FRZ);
    @(negedge clk);
    mem_ready = 1;
    #1 chk("mw_rearm_release", ctl(), FREE);

    // Timeout into HALT
    do_reset();
    MEM_RAM_Enable = 1; mem_ready = 0;
    for (int c = 0; c < 16; c++) begin
      #1 chk($sformatf("to_frz%0d", c), ctl(), FRZ);
      chk($sformatf("to_noerr%0d", c), halt_err, 0);
      @(negedge clk);
    end
    #1 chk("halt_err", halt_err, 1);
    chk("halt_ctl", ctl(), HALTC);
    chk("halt_stall_cnt", stall_cnt, 16);
    mem_ready = 1; EX_branch_taken = 1;
    @(negedge clk);
    #1 chk("halt_sticky_ctl", ctl(), HALTC);
    chk("halt_no_count", stall_cnt, 16);
    chk("halt_no_flush", flush_cnt, 0);
    Reset = 1;
    #1 chk("async_rst_halt", halt_err, 0);
    chk("async_rst_stall", stall_cnt, 0);
    @(negedge clk);
    Reset = 0; idle_inputs();
    #1 chk("post_halt_ctl", ctl(), FREE);

    // Saturation: 20 separate load-use bubbles
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_loaduse();
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
    end
    chk("sat_cnt4", stall_cnt4, 15);
    chk("sat_cnt16", stall_cnt, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
